// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and MDU state encoding
package pipe_pkg;

    localparam int REG_W_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multiply/divide unit busy sequencer with down-counter
module mdu_seq
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output mdu_state_t state,
    output logic       mdubusy,
    output logic       mdudone
);

    // MDU_LAT is expected in 2..255 so the reload value fits in 8 bits.
    localparam logic [7:0] RELOAD = 8'(MDU_LAT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            mdubusy <= 1'b0;
            mdudone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mdudone <= 1'b0;
                    if (start) begin
                        count   <= RELOAD;
                        state   <= BUSY;
                        mdubusy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (count == 8'd0) begin
                        state   <= DONE;
                        mdubusy <= 1'b0;
                        mdudone <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DONE: begin
                    mdudone <= 1'b0;
                    // A start landing on the done cycle chains straight into the next op.
                    if (start) begin
                        count   <= RELOAD;
                        state   <= BUSY;
                        mdubusy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mdubusy <= 1'b0;
                    mdudone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and stall controller
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pcsrcD,
    input  logic             mdustartE,
    input  logic             mduuseD,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mdubusy,
    output logic             mdudone,
    output logic [CNT_W-1:0] stallcnt
);

    mdu_state_t mdu_state;
    logic       lwstall;
    logic       branchstall;
    logic       mdustall;
    logic       stall;
    logic       e_hit;
    logic       m_hit;

    mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (mdustartE),
        .state  (mdu_state),
        .mdubusy(mdubusy),
        .mdudone(mdudone)
    );

    // M stage is newer than W, so it wins when both target the same register.
    always_comb begin
        forwardAE = FWD_RF;
        if (rsE != '0 && regwriteM && writeregM == rsE)
            forwardAE = FWD_M;
        else if (rsE != '0 && regwriteW && writeregW == rsE)
            forwardAE = FWD_W;

        forwardBE = FWD_RF;
        if (rtE != '0 && regwriteM && writeregM == rtE)
            forwardBE = FWD_M;
        else if (rtE != '0 && regwriteW && writeregW == rtE)
            forwardBE = FWD_W;
    end

    assign forwardAD = (rsD != '0) && regwriteM && (writeregM == rsD);
    assign forwardBD = (rtD != '0) && regwriteM && (writeregM == rtD);

    assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD)) && (rtE != '0);

    assign e_hit = regwriteE && (writeregE != '0) &&
                   ((writeregE == rsD) || (writeregE == rtD));
    assign m_hit = memtoregM && (writeregM != '0) &&
                   ((writeregM == rsD) || (writeregM == rtD));
    assign branchstall = branchD && (e_hit || m_hit);

    assign mdustall = mduuseD &&
                      ((mdu_state == BUSY) || (mdu_state == IDLE && mdustartE));

    assign stall  = lwstall || branchstall || mdustall;
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    // A stalled branch stays in D and is re-resolved, so it must not flush.
    assign flushD = (pcsrcD || jumpD) && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallcnt <= '0;
        else if (stall && stallcnt != '1)
            stallcnt <= stallcnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jumpD, pcsrcD, mdustartE, mduuseD;
    logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       mdubusy, mdudone;
    logic [3:0] stallcnt;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_cnt = 4'd0;
    logic [3:0] sb[$];
    logic [3:0] sb_exp;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .MDU_LAT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD),
        .mdustartE(mdustartE), .mduuseD(mduuseD),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mdubusy(mdubusy), .mdudone(mdudone), .stallcnt(stallcnt)
    );

    // Scoreboard: each expected stallcnt pushed before an edge is compared just after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_exp = sb.pop_front();
            checks++;
            if (stallcnt !== sb_exp) begin
                errors++;
                $display("FAIL stallcnt_sb: got %0d expected %0d at %0t", stallcnt, sb_exp, $time);
            end
        end
    end

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; jumpD = 0; pcsrcD = 0; mdustartE = 0; mduuseD = 0;
    endtask

    task automatic advance(input bit exp_stall);
        if (exp_stall && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        sb.push_back(model_cnt);
        @(posedge clk);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        clear_inputs();
        model_cnt = 4'd0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (stallcnt !== 4'd0 || mdubusy !== 1'b0 || mdudone !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d busy=%b done=%b expected 0 0 0", stallcnt, mdubusy, mdudone);
        end
        regwriteM = 1; writeregM = 3; rsE = 3;
        #1;
        checks++;
        if (forwardAE !== 2'b10) begin
            errors++;
            $display("FAIL reset_comb_fwd: got %b expected 10", forwardAE);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8;
        rsE = 8; rtE = 8; rsD = 8; rtD = 8;
        #1;
        checks++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b10 || forwardAD !== 1'b1 || forwardBD !== 1'b1 || stallD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_m_priority: got AE=%b BE=%b AD=%b BD=%b st=%b expected 10 10 1 1 0",
                     forwardAE, forwardBE, forwardAD, forwardBD, stallD);
        end
        regwriteM = 0;
        #1;
        checks++;
        if (forwardAE !== 2'b01 || forwardAD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_w: got AE=%b AD=%b expected 01 0", forwardAE, forwardAD);
        end
        regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0; rsD = 0;
        #1;
        checks++;
        if (forwardAE !== 2'b00 || forwardAD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_reg0: got AE=%b AD=%b expected 00 0", forwardAE, forwardAD);
        end
        rtE = 5; writeregW = 5; writeregM = 6;
        #1;
        checks++;
        if (forwardBE !== 2'b01 || forwardAE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_be_w: got BE=%b AE=%b expected 01 00", forwardBE, forwardAE);
        end
        advance(1'b0);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        memtoregE = 1; rtE = 9; rsD = 9; rtD = 3;
        #1;
        checks++;
        if (stallF !== 1'b1 || stallD !== 1'b1 || flushE !== 1'b1) begin
            errors++;
            $display("FAIL lw_stall: got F=%b D=%b E=%b expected 1 1 1", stallF, stallD, flushE);
        end
        advance(1'b1);
        @(negedge clk);
        memtoregE = 0;
        #1;
        checks++;
        if (stallD !== 1'b0 || flushE !== 1'b0) begin
            errors++;
            $display("FAIL lw_one_cycle: got D=%b E=%b expected 0 0", stallD, flushE);
        end
        advance(1'b0);
        @(negedge clk);
        memtoregE = 1; rtE = 0; rsD = 0; rtD = 0;
        #1;
        checks++;
        if (stallD !== 1'b0) begin
            errors++;
            $display("FAIL lw_reg0: got %b expected 0", stallD);
        end
        advance(1'b0);
        @(negedge clk);
        rtE = 9; rtD = 9; rsD = 2;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            errors++;
            $display("FAIL lw_rtd: got %b expected 1", stallD);
        end
        advance(1'b1);
        @(negedge clk);
        clear_inputs();
        advance(1'b0);
    endtask

    task automatic test_branch();
        @(negedge clk);
        branchD = 1; pcsrcD = 1; regwriteE = 1; writeregE = 4; rsD = 4;
        #1;
        checks++;
        if (stallD !== 1'b1 || stallF !== 1'b1 || flushD !== 1'b0) begin
            errors++;
            $display("FAIL br_stall: got D=%b F=%b flushD=%b expected 1 1 0", stallD, stallF, flushD);
        end
        advance(1'b1);
        @(negedge clk);
        writeregE = 0;
        #1;
        checks++;
        if (stallD !== 1'b0 || flushD !== 1'b1) begin
            errors++;
            $display("FAIL br_resolve: got D=%b flushD=%b expected 0 1", stallD, flushD);
        end
        advance(1'b0);
        @(negedge clk);
        regwriteE = 0; memtoregM = 1; writeregM = 7; rtD = 7;
        #1;
        checks++;
        if (stallD !== 1'b1 || flushD !== 1'b0) begin
            errors++;
            $display("FAIL br_load_m: got D=%b flushD=%b expected 1 0", stallD, flushD);
        end
        advance(1'b1);
        @(negedge clk);
        branchD = 0; pcsrcD = 0; memtoregM = 0; jumpD = 1;
        #1;
        checks++;
        if (stallD !== 1'b0 || flushD !== 1'b1) begin
            errors++;
            $display("FAIL jump_flush: got D=%b flushD=%b expected 0 1", stallD, flushD);
        end
        advance(1'b0);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mdu();
        apply_reset();
        @(negedge clk);
        mdustartE = 1; mduuseD = 1;
        #1;
        checks++;
        if (stallD !== 1'b1 || mdubusy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_start: got stallD=%b busy=%b expected 1 0", stallD, mdubusy);
        end
        advance(1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            mdustartE = 0;
            #1;
            checks++;
            if (mdubusy !== 1'b1 || stallD !== 1'b1 || mdudone !== 1'b0) begin
                errors++;
                $display("FAIL mdu_busy_t%0d: got busy=%b stallD=%b done=%b expected 1 1 0", i, mdubusy, stallD, mdudone);
            end
            advance(1'b1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mdudone !== 1'b1 || mdubusy !== 1'b0 || stallD !== 1'b0) begin
            errors++;
            $display("FAIL mdu_done: got done=%b busy=%b stallD=%b expected 1 0 0", mdudone, mdubusy, stallD);
        end
        mdustartE = 1; mduuseD = 0;
        advance(1'b0);
        @(negedge clk);
        mdustartE = 0;
        #1;
        checks++;
        if (mdubusy !== 1'b1 || mdudone !== 1'b0) begin
            errors++;
            $display("FAIL mdu_b2b: got busy=%b done=%b expected 1 0", mdubusy, mdudone);
        end
        for (int i = 0; i < 8; i++) advance(1'b0);
        @(negedge clk);
        checks++;
        if (mdudone !== 1'b1) begin
            errors++;
            $display("FAIL mdu_b2b_done: got %b expected 1", mdudone);
        end
        advance(1'b0);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        mdustartE = 1; mduuseD = 1;
        advance(1'b1);
        @(negedge clk);
        mdustartE = 0;
        for (int i = 0; i < 3; i++) advance(1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_cnt = 4'd0;
        #1;
        checks++;
        if (mdubusy !== 1'b0 || mdudone !== 1'b0 || stallcnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b cnt=%0d expected 0 0 0", mdubusy, mdudone, stallcnt);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mduuseD = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (mdudone !== 1'b0 || mdubusy !== 1'b0) seen = 1'b1;
            advance(1'b0);
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_abort: got done/busy activity=1 expected 0");
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        @(negedge clk);
        memtoregE = 1; rtE = 9; rsD = 9;
        for (int i = 0; i < 20; i++) advance(1'b1);
        @(negedge clk);
        checks++;
        if (stallcnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_value: got %0d expected 15", stallcnt);
        end
        advance(1'b1);
        @(negedge clk);
        checks++;
        if (stallcnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", stallcnt);
        end
        clear_inputs();
        advance(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mdu();
        test_reset_mid();
        test_saturation();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Produces the per-stage hold (stall) and clear (flush) controls that drive the enable/clear inputs of the inter-stage pipeline registers.
- Produces the forwarding mux selects for the D and E stages.
- Contains the sequencer for the multi-cycle multiply/divide unit (MDU) and a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register-specifier width.
- MDU_LAT, 8, MDU busy cycles per operation (legal range 2..255).
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rsD, rtD  in  REG_W  source specifiers, D stage
- rsE, rtE  in  REG_W  source specifiers, E stage
- writeregE, writeregM, writeregW  in  REG_W  destination specifiers
- regwriteE, regwriteM, regwriteW  in  1  register-write flags
- memtoregE, memtoregM  in  1  load-in-stage flags
- branchD  in  1  branch decoded in D
- jumpD  in  1  jump decoded in D
- pcsrcD  in  1  branch resolved taken in D
- mdustartE  in  1  mult/div issuing in E
- mduuseD  in  1  D instruction is mfhi/mflo/mult/div
- stallF  out  1  hold PC register (1 = hold)
- stallD  out  1  hold IF/ID register (1 = hold)
- flushD  out  1  clear IF/ID register
- flushE  out  1  clear ID/EX register
- forwardAD, forwardBD  out  1  D-stage compare operand forward from M
- forwardAE, forwardBE  out  2  E-stage ALU operand select: 00 = RF, 01 = W result, 10 = M result
- mdubusy  out  1  MDU operation in progress
- mdudone  out  1  one-cycle pulse, result written to HI/LO
- stallcnt  out  CNT_W  count of cycles with stallD = 1

Behaviour:
- Reset (reset = 0, async):
  - MDU FSM goes to IDLE; stallcnt = 0; mdubusy = 0; mdudone = 0.
  - Combinational outputs follow their inputs during reset. The top level holds the pipeline registers in reset, so no pipeline effect results.
- Forwarding, E stage (forwardAE; forwardBE is identical with rtE):
  - 10 if rsE != 0 and regwriteM and writeregM == rsE.
  - Else 01 if rsE != 0 and regwriteW and writeregW == rsE.
  - Else 00.
  - M has priority over W.
- Forwarding, D stage: forwardAD = rsD != 0 and regwriteM and writeregM == rsD; forwardBD likewise with rtD.
- Register 0 is never forwarded and never causes a stall.
- lwstall = memtoregE and (rtE == rsD or rtE == rtD) and rtE != 0.
- branchstall = branchD and any of:
  - regwriteE and writeregE != 0 and writeregE matches rsD or rtD;
  - memtoregM and writeregM != 0 and writeregM matches rsD or rtD.
- mdustall = mduuseD and (state == BUSY, or state == IDLE and mdustartE). A second MDU operation or a HI/LO read never passes a running operation.
- Output equations:
  - stallF = stallD = lwstall | branchstall | mdustall.
  - flushE = stallD (inserts a bubble).
  - flushD = (pcsrcD | jumpD) & ~stallD. A branch that is stalling is held, not flushed; it is re-evaluated next cycle.
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE, mdustartE = 1: load count = MDU_LAT-1, go to BUSY.
  - BUSY: decrement count each cycle; at count == 0 go to DONE.
  - DONE: mdudone = 1 for one cycle, then go to IDLE. If mdustartE = 1 in DONE, reload and go directly to BUSY (back-to-back operation).
  - mdustartE in BUSY is ignored; it cannot occur because of mdustall.
  - mdubusy = (state == BUSY).
  - MDU_LAT = 8 gives: start at cycle t; BUSY for cycles t+1..t+8; DONE at t+9.
- stallcnt: increments every clock with stallD = 1; saturates at all-ones; never wraps.
- Asynchronous reset mid-operation aborts the MDU operation (state goes to IDLE, no mdudone) and clears stallcnt.

Decomposition:
- Shared package pipe_pkg:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - MDU state enum {IDLE, BUSY, DONE}.
  - REG_W default.
- Sub-module mdu_seq: the FSM plus the down-counter; outputs mdubusy and mdudone.
- All forwarding and stall logic stays flat in hazard_ctrl.

Test Plan:
- Forwarding: regwriteM = 1, writeregM = 8, regwriteW = 1, writeregW = 8, rsE = 8 -> forwardAE = 10. Drop regwriteM -> forwardAE = 01. Set writeregM = writeregW = 0 with rsE = 0 -> forwardAE = 00.
- Load-use: memtoregE = 1, rtE = 9, rsD = 9 -> stallF = stallD = flushE = 1 for exactly one cycle; stallcnt increments by 1. Repeat with rtE = 0 -> no stall.
- Branch hazard: branchD = 1, pcsrcD = 1, regwriteE = 1, writeregE = rsD = 4 -> stallD = 1 and flushD = 0. Next cycle, with writeregE cleared -> stallD = 0 and flushD = 1.
- MDU: pulse mdustartE at t with MDU_LAT = 8, hold mduuseD = 1 -> stallD = 1 for cycles t..t+8, mdudone = 1 at t+9, stallD = 0 at t+9. Back-to-back start in DONE -> mdubusy = 1 the following cycle.
- Reset mid-operation: assert reset during BUSY -> mdubusy = 0 immediately, no mdudone pulse, stallcnt = 0.
- Saturation: with CNT_W = 4, hold stallD for 20 cycles -> stallcnt = 15 and stays at 15.
